// File: rtl/alu_pkg.sv
// Shared types, packet geometry and CRC3 helper for the ALU serial response receiver.
package alu_pkg;

    typedef enum logic {PKT_DATA = 1'b0, PKT_CTL = 1'b1} packet_type_t;
    typedef enum logic [1:0] {ST_WAIT_FIRST, ST_DATA, ST_WAIT_CTL} rsp_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_WAIT_HIGH} rx_state_t;

    localparam int PKT_LEN = 11;

    // Error CTL flag layout: err[5:0] = {DATA, CRC, OP, DATA, CRC, OP}
    localparam int ERR_OP_BIT   = 0;
    localparam int ERR_DATA_BIT = 2;
    localparam int ERR_COPY_OFS = 3;

    // x^3+x+1, init 000, message shifted in MSB first
    function automatic logic [2:0] crc3_calc(input logic [36:0] msg);
        logic [2:0] c;
        logic       fb;
        c = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb = msg[i] ^ c[2];
            c  = {c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_packet_rx.sv
// Bit-level deframer: start detect, type + 8 payload bits MSB first, stop check.
module alu_packet_rx
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sout,
    output logic         pkt_valid,
    output packet_type_t pkt_type,
    output logic [7:0]   pkt_data,
    output logic         pkt_stop_err,
    output logic         busy
);

    localparam logic [3:0] STOP_IDX = 4'(PKT_LEN - 2);

    rx_state_t  state;
    logic [3:0] bit_cnt;
    logic [8:0] shift;

    assign busy = (state != RX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RX_IDLE;
            bit_cnt      <= 4'd0;
            shift        <= 9'd0;
            pkt_valid    <= 1'b0;
            pkt_type     <= PKT_DATA;
            pkt_data     <= 8'd0;
            pkt_stop_err <= 1'b0;
        end else begin
            pkt_valid    <= 1'b0;
            pkt_stop_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!sout) begin
                        state   <= RX_SHIFT;
                        bit_cnt <= 4'd0;
                    end
                end
                RX_SHIFT: begin
                    if (bit_cnt == STOP_IDX) begin
                        bit_cnt <= 4'd0;
                        if (sout) begin
                            pkt_valid <= 1'b1;
                            pkt_type  <= packet_type_t'(shift[8]);
                            pkt_data  <= shift[7:0];
                            state     <= RX_IDLE;
                        end else begin
                            // Bad stop: wait for the line to go high before hunting a new start
                            pkt_stop_err <= 1'b1;
                            state        <= RX_WAIT_HIGH;
                        end
                    end else begin
                        shift   <= {shift[7:0], sout};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (sout) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_rsp_deserializer.sv
// Response assembler: DATA/CTL sequencing, CRC3/parity checks, inter-packet timeout.
module alu_rsp_deserializer
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sout,
    output logic        rsp_valid,
    output logic [31:0] rsp_C,
    output logic [3:0]  rsp_flags,
    output logic        rsp_err,
    output logic [5:0]  rsp_err_flags,
    output logic        rsp_chk_ok,
    output logic        frame_err
);

    localparam int             CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic         pkt_valid;
    packet_type_t pkt_type;
    logic [7:0]   pkt_data;
    logic         pkt_stop_err;
    logic         rx_busy;

    alu_packet_rx u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .sout         (sout),
        .pkt_valid    (pkt_valid),
        .pkt_type     (pkt_type),
        .pkt_data     (pkt_data),
        .pkt_stop_err (pkt_stop_err),
        .busy         (rx_busy)
    );

    rsp_state_t       state;
    logic [2:0]       byte_cnt;
    logic [31:0]      c_shift;
    logic [CNT_W-1:0] idle_cnt;

    logic       abort, accept_data, emit_norm, emit_err, idle_run;
    logic [5:0] err_bits;
    logic       err_chk_ok;
    logic       crc_ok;

    assign err_bits   = pkt_data[6:1];
    assign err_chk_ok = ~^pkt_data &&
        (err_bits[ERR_DATA_BIT:ERR_OP_BIT] ==
         err_bits[ERR_DATA_BIT+ERR_COPY_OFS:ERR_OP_BIT+ERR_COPY_OFS]);
    assign crc_ok     = (crc3_calc({c_shift, 1'b0, pkt_data[6:3]}) == pkt_data[2:0]);

    always_comb begin
        abort       = 1'b0;
        accept_data = 1'b0;
        emit_norm   = 1'b0;
        emit_err    = 1'b0;
        idle_run    = 1'b0;
        if (pkt_stop_err) begin
            abort = 1'b1;
        end else if (pkt_valid) begin
            case (state)
                ST_WAIT_FIRST: begin
                    if (pkt_type == PKT_DATA) accept_data = 1'b1;
                    else if (pkt_data[7])     emit_err    = 1'b1;
                    else                      abort       = 1'b1;
                end
                ST_DATA: begin
                    if (pkt_type == PKT_DATA) accept_data = 1'b1;
                    else                      abort       = 1'b1;
                end
                ST_WAIT_CTL: begin
                    if (pkt_type == PKT_CTL && !pkt_data[7]) emit_norm = 1'b1;
                    else                                     abort     = 1'b1;
                end
                default: abort = 1'b1;
            endcase
        end else if (state != ST_WAIT_FIRST && !rx_busy && sout) begin
            // Idle-high gap inside a response
            if (idle_cnt == IDLE_LAST) abort    = 1'b1;
            else                       idle_run = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_WAIT_FIRST;
            byte_cnt      <= 3'd0;
            c_shift       <= 32'd0;
            idle_cnt      <= '0;
            rsp_valid     <= 1'b0;
            rsp_C         <= 32'd0;
            rsp_flags     <= 4'd0;
            rsp_err       <= 1'b0;
            rsp_err_flags <= 6'd0;
            rsp_chk_ok    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            frame_err <= abort;
            idle_cnt  <= idle_run ? idle_cnt + 1'b1 : '0;
            if (abort) begin
                state    <= ST_WAIT_FIRST;
                byte_cnt <= 3'd0;
                c_shift  <= 32'd0;
            end else if (accept_data) begin
                c_shift  <= {c_shift[23:0], pkt_data};
                byte_cnt <= byte_cnt + 3'd1;
                state    <= (byte_cnt == 3'd3) ? ST_WAIT_CTL : ST_DATA;
            end else if (emit_norm || emit_err) begin
                rsp_valid     <= 1'b1;
                rsp_C         <= emit_norm ? c_shift : 32'd0;
                rsp_flags     <= emit_norm ? pkt_data[6:3] : 4'd0;
                rsp_err       <= emit_err;
                rsp_err_flags <= emit_err ? err_bits : 6'd0;
                rsp_chk_ok    <= emit_norm ? crc_ok : err_chk_ok;
                state         <= ST_WAIT_FIRST;
                byte_cnt      <= 3'd0;
                c_shift       <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rsp_deserializer.sv
// Directed bench for alu_rsp_deserializer with an expected-response queue and independent monitor.
module tb_alu_rsp_deserializer;

    logic        clk;
    logic        rst_n;
    logic        sout;
    logic        rsp_valid;
    logic [31:0] rsp_C;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [5:0]  rsp_err_flags;
    logic        rsp_chk_ok;
    logic        frame_err;

    alu_rsp_deserializer #(.TIMEOUT_CYCLES(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sout          (sout),
        .rsp_valid     (rsp_valid),
        .rsp_C         (rsp_C),
        .rsp_flags     (rsp_flags),
        .rsp_err       (rsp_err),
        .rsp_err_flags (rsp_err_flags),
        .rsp_chk_ok    (rsp_chk_ok),
        .frame_err     (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ferr;
        logic [31:0] c;
        logic [3:0]  flags;
        logic        err;
        logic [5:0]  ef;
        logic        ok;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({rsp_valid, frame_err, rsp_C, rsp_flags, rsp_err, rsp_err_flags, rsp_chk_ok});
    endfunction

    task automatic push_rsp(input logic [31:0] c, input logic [3:0] f, input logic e,
                            input logic [5:0] ef, input logic ok);
        exp_t x;
        x = '{ferr: 1'b0, c: c, flags: f, err: e, ef: ef, ok: ok};
        exp_q.push_back(x);
    endtask

    task automatic push_ferr();
        exp_t x;
        x = '0;
        x.ferr = 1'b1;
        exp_q.push_back(x);
    endtask

    // Monitor: every output event must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && (rsp_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {62'd0, rsp_valid, frame_err}, 64'd0);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                if (x.ferr)
                    check("frame_err_event", {62'd0, frame_err, rsp_valid}, 64'b10);
                else
                    check("rsp_event",
                          64'({frame_err, rsp_valid, rsp_C, rsp_flags, rsp_err, rsp_err_flags, rsp_chk_ok}),
                          64'({1'b0, 1'b1, x.c, x.flags, x.err, x.ef, x.ok}));
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        sout = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_pkt(input logic typ, input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic send_data4(input logic [31:0] c);
        for (int i = 3; i >= 0; i--) send_pkt(1'b0, c[8*i +: 8], 1'b1);
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        idle(3);
    endtask

    initial begin
        rst_n = 1'b0;
        sout  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        idle(3);

        // Zero result, flags 0010, CRC 110, plus exact valid latency and width
        push_rsp(32'd0, 4'b0010, 1'b0, 6'd0, 1'b1);
        send_data4(32'd0);
        send_pkt(1'b1, 8'h16, 1'b1);
        @(negedge clk);
        check("latency_n1", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        check("latency_n2", {63'd0, rsp_valid}, 64'd1);
        @(negedge clk);
        check("pulse_width", {63'd0, rsp_valid}, 64'd0);
        drain("t1_zero_ok");

        push_rsp(32'd0, 4'b0010, 1'b0, 6'd0, 1'b0);
        send_data4(32'd0);
        send_pkt(1'b1, 8'h17, 1'b1);
        drain("t2_bad_crc");

        // C = 01000002, flags 1001 -> CRC 100, with gaps between packets
        push_rsp(32'h0100_0002, 4'b1001, 1'b0, 6'd0, 1'b1);
        send_pkt(1'b0, 8'h01, 1'b1);
        idle(2);
        send_pkt(1'b0, 8'h00, 1'b1);
        send_pkt(1'b0, 8'h00, 1'b1);
        idle(5);
        send_pkt(1'b0, 8'h02, 1'b1);
        send_pkt(1'b1, 8'h4C, 1'b1);
        drain("nonzero_crc");

        // Error CTL packets
        push_rsp(32'd0, 4'd0, 1'b1, 6'b001001, 1'b1);
        send_pkt(1'b1, 8'h93, 1'b1);
        push_rsp(32'd0, 4'd0, 1'b1, 6'b001001, 1'b0);
        send_pkt(1'b1, 8'h92, 1'b1);
        push_rsp(32'd0, 4'd0, 1'b1, 6'b100100, 1'b1);
        send_pkt(1'b1, 8'hC9, 1'b1);
        push_rsp(32'd0, 4'd0, 1'b1, 6'b001010, 1'b0);
        send_pkt(1'b1, 8'h95, 1'b1);
        drain("t3_err_ctl");

        // CTL after 2 DATA, then a clean response
        push_ferr();
        send_pkt(1'b0, 8'hAA, 1'b1);
        send_pkt(1'b0, 8'hBB, 1'b1);
        send_pkt(1'b1, 8'h16, 1'b1);
        push_rsp(32'd0, 4'b0010, 1'b0, 6'd0, 1'b1);
        send_data4(32'd0);
        send_pkt(1'b1, 8'h16, 1'b1);
        drain("t4_early_ctl");

        // Normal-looking CTL with no DATA; 5th DATA; error-flavoured CTL after 4 DATA
        push_ferr();
        send_pkt(1'b1, 8'h16, 1'b1);
        push_ferr();
        send_data4(32'hAABB_CCDD);
        send_pkt(1'b0, 8'hEE, 1'b1);
        push_ferr();
        send_data4(32'h1122_3344);
        send_pkt(1'b1, 8'h93, 1'b1);
        drain("sequence_errs");

        // Bad stop bit, then an error CTL decodes normally
        push_ferr();
        send_pkt(1'b0, 8'h55, 1'b0);
        idle(2);
        push_rsp(32'd0, 4'd0, 1'b1, 6'b001001, 1'b1);
        send_pkt(1'b1, 8'h93, 1'b1);
        drain("t5_stop_err");

        // Timeout after 2 DATA and 40 idle cycles
        push_ferr();
        send_pkt(1'b0, 8'h01, 1'b1);
        send_pkt(1'b0, 8'h00, 1'b1);
        idle(40);
        drain("t5_timeout");

        // 25-cycle gap is within budget
        push_rsp(32'h0100_0002, 4'b1001, 1'b0, 6'd0, 1'b1);
        send_pkt(1'b0, 8'h01, 1'b1);
        send_pkt(1'b0, 8'h00, 1'b1);
        idle(25);
        send_pkt(1'b0, 8'h00, 1'b1);
        send_pkt(1'b0, 8'h02, 1'b1);
        send_pkt(1'b1, 8'h4C, 1'b1);
        drain("gap_no_timeout");

        // Reset in the middle of the 3rd DATA packet
        send_pkt(1'b0, 8'h11, 1'b1);
        send_pkt(1'b0, 8'h22, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        sout  = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_in_reset", all_outs(), 64'd0);
        rst_n = 1'b1;
        idle(12);
        check("t6_after_reset", all_outs(), 64'd0);
        push_rsp(32'h0100_0002, 4'b1001, 1'b0, 6'd0, 1'b1);
        send_data4(32'h0100_0002);
        send_pkt(1'b1, 8'h4C, 1'b1);
        drain("t6_recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1);
    end

endmodule
